// File: rtl/vectored_int_ctrl_if.sv
// Bus between the vectored interrupt controller and the processor control unit.
// Per-source done/mask signals plus the request/ack/eoi handshake.
interface vectored_int_ctrl_if #(
    parameter int NSRC = 4,
    parameter int IDW  = 2
) ();
    logic [NSRC-1:0] done;
    logic            mask_we;
    logic [NSRC-1:0] mask_wd;
    logic [NSRC-1:0] mask;
    logic            int_ack;
    logic            eoi;
    logic            interrupt;
    logic [31:0]     int_addr;
    logic [IDW-1:0]  int_id;
    logic [NSRC-1:0] pending;
    logic            in_service;

    modport master (
        output done, mask_we, mask_wd, int_ack, eoi,
        input  mask, interrupt, int_addr, int_id, pending, in_service
    );

    modport slave (
        input  done, mask_we, mask_wd, int_ack, eoi,
        output mask, interrupt, int_addr, int_id, pending, in_service
    );
endinterface

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, software mask,
// round-robin arbitration and a single non-nesting in-service slot.
module vectored_int_ctrl #(
    parameter int              NSRC       = 4,
    parameter int              IDW        = 2,
    parameter logic [31:0]     VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0]     VEC_STRIDE = 32'h0000_0010,
    parameter logic [NSRC-1:0] MASK_RESET = '1
) (
    input  logic               clk,
    input  logic               reset,
    vectored_int_ctrl_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] done_q, done_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [IDW-1:0]  sel_id_q, sel_id_d;
    logic [IDW-1:0]  last_id_q, last_id_d;
    logic            interrupt_q, interrupt_d;
    logic            in_service_q, in_service_d;
    logic [31:0]     int_addr_q, int_addr_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [IDW-1:0]  winner;
    logic            win_found;
    logic            ack_ok;

    assign rise     = bus.done & ~done_q;
    assign eligible = pending_q & mask_q;
    assign ack_ok   = (state_q == ST_REQ) && bus.int_ack;
    assign done_d   = bus.done;
    assign mask_d   = bus.mask_we ? bus.mask_wd : mask_q;

    // A new edge on the source being acknowledged wins over the clear.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pending
        assign pending_d[gi] = rise[gi] |
                               (pending_q[gi] & ~(ack_ok && (sel_id_q == IDW'(gi))));
    end

    // Round-robin scan starting just after the last acknowledged source.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        idx       = 0;
        cand      = '0;
        winner    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NSRC; k++) begin
            idx  = (int'(last_id_q) + k) % NSRC;
            cand = IDW'(idx);
            if (!win_found && eligible[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_id_d     = sel_id_q;
        last_id_d    = last_id_q;
        interrupt_d  = interrupt_q;
        in_service_d = in_service_q;
        int_addr_d   = int_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    sel_id_d    = winner;
                    int_addr_d  = VEC_BASE + (32'(winner) * VEC_STRIDE);
                    interrupt_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.int_ack) begin
                    last_id_d    = sel_id_q;
                    interrupt_d  = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            done_q       <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RESET;
            sel_id_q     <= '0;
            last_id_q    <= IDW'(NSRC - 1);
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
            int_addr_q   <= VEC_BASE;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            sel_id_q     <= sel_id_d;
            last_id_q    <= last_id_d;
            interrupt_q  <= interrupt_d;
            in_service_q <= in_service_d;
            int_addr_q   <= int_addr_d;
        end
    end

    assign bus.mask       = mask_q;
    assign bus.pending    = pending_q;
    assign bus.interrupt  = interrupt_q;
    assign bus.int_addr   = int_addr_q;
    assign bus.int_id     = sel_id_q;
    assign bus.in_service = in_service_q;

endmodule
